// File: rtl/seg7_scan_capture.sv
// Rebuilds the four digit patterns of a scanned, multiplexed 7-seg bus and publishes them once per complete frame.
// Optional hex decoder is built when SEG7_RX_HEXDEC_EN is defined.
module seg7_scan_capture #(
  parameter int STABLE_CYC  = 2,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk_disp,
  input  logic        rst,
  input  logic [6:0]  Catodo,
  input  logic [3:0]  Seleccion,
  output logic [6:0]  Unidades_rx,
  output logic [6:0]  Decenas_rx,
  output logic [6:0]  Actividad_rx,
  output logic [6:0]  Estado_rx,
  output logic [15:0] Digito_hex,
  output logic [3:0]  Hex_valido,
  output logic        Trama_lista,
  output logic        Error_sel,
  output logic        Sin_senal
);

  localparam int SW = $clog2(STABLE_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [6:0]    BLANK  = 7'h7F;
  localparam logic [SW-1:0] ST_MAX = SW'(STABLE_CYC);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {ESPERA, ESP_D, ESP_A, ESP_E} state_t;

  logic [6:0]    cat_p0, cat_p1;
  logic [3:0]    sel_p0, sel_p1;
  logic [SW-1:0] stab_cnt, stab_nxt;
  logic [TW-1:0] to_cnt;
  logic          cap_done, done_eff, same_p1, onehot_p1, multi_p1, cap_vld_p1, frame_done;
  logic [6:0]    sh_u, sh_d, sh_a;
  state_t        state;

  // Stage p0: pins registered once; stage p1: previous registered pair for the stability compare
  always_ff @(posedge clk_disp) begin
    cat_p0 <= Catodo;
    sel_p0 <= Seleccion;
    cat_p1 <= cat_p0;
    sel_p1 <= sel_p0;
  end

  // Stage p1: dwell qualification and capture decision
  always_comb begin
    same_p1   = (cat_p0 == cat_p1) && (sel_p0 == sel_p1);
    onehot_p1 = $onehot(sel_p0);
    multi_p1  = (sel_p0 != 4'h0) && !onehot_p1;
    stab_nxt  = SW'(1);
    if (same_p1)
      stab_nxt = (stab_cnt == ST_MAX) ? ST_MAX : stab_cnt + 1'b1;
    done_eff   = same_p1 && cap_done;
    cap_vld_p1 = (stab_nxt == ST_MAX) && !done_eff && onehot_p1;
    frame_done = cap_vld_p1 && sel_p0[3] && (state == ESP_E);
  end

  always_ff @(posedge clk_disp or posedge rst) begin
    if (rst) begin
      stab_cnt     <= '0;
      cap_done     <= 1'b0;
      state        <= ESPERA;
      sh_u         <= BLANK;
      sh_d         <= BLANK;
      sh_a         <= BLANK;
      Unidades_rx  <= BLANK;
      Decenas_rx   <= BLANK;
      Actividad_rx <= BLANK;
      Estado_rx    <= BLANK;
      Trama_lista  <= 1'b0;
      Error_sel    <= 1'b0;
      to_cnt       <= '0;
    end else begin
      stab_cnt    <= stab_nxt;
      cap_done    <= cap_vld_p1 | done_eff;
      Trama_lista <= frame_done;
      if (multi_p1)
        Error_sel <= 1'b1;
      if (frame_done)
        to_cnt <= '0;
      else if (to_cnt != TO_MAX)
        to_cnt <= to_cnt + 1'b1;
      if (cap_vld_p1) begin
        if (sel_p0[0]) sh_u <= cat_p0;
        if (sel_p0[1]) sh_d <= cat_p0;
        if (sel_p0[2]) sh_a <= cat_p0;
        // Any out-of-order capture restarts the frame; a stray U doubles as a fresh start
        case (state)
          ESPERA: if (sel_p0[0]) state <= ESP_D;
          ESP_D:  state <= sel_p0[1] ? ESP_A : (sel_p0[0] ? ESP_D : ESPERA);
          ESP_A:  state <= sel_p0[2] ? ESP_E : (sel_p0[0] ? ESP_D : ESPERA);
          ESP_E: begin
            state <= sel_p0[0] ? ESP_D : ESPERA;
            if (sel_p0[3]) begin
              Unidades_rx  <= sh_u;
              Decenas_rx   <= sh_d;
              Actividad_rx <= sh_a;
              Estado_rx    <= cat_p0;
            end
          end
        endcase
      end
    end
  end

  assign Sin_senal = (to_cnt == TO_MAX);

`ifdef SEG7_RX_HEXDEC_EN
  // Returns {legal, nibble}; active-low gfedcba glyphs
  function automatic logic [4:0] dec7(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h40: r = 5'h10;  7'h79: r = 5'h11;  7'h24: r = 5'h12;  7'h30: r = 5'h13;
      7'h19: r = 5'h14;  7'h12: r = 5'h15;  7'h02: r = 5'h16;  7'h78: r = 5'h17;
      7'h00: r = 5'h18;  7'h10: r = 5'h19;  7'h08: r = 5'h1A;  7'h03: r = 5'h1B;
      7'h46: r = 5'h1C;  7'h21: r = 5'h1D;  7'h06: r = 5'h1E;  7'h0E: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  logic [4:0] du, dd, da, de;
  always_comb begin
    du = dec7(Unidades_rx);
    dd = dec7(Decenas_rx);
    da = dec7(Actividad_rx);
    de = dec7(Estado_rx);
    Digito_hex = {de[3:0], da[3:0], dd[3:0], du[3:0]};
    Hex_valido = {de[4], da[4], dd[4], du[4]};
  end
`else
  assign Digito_hex = 16'h0;
  assign Hex_valido = 4'h0;
`endif

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Scoreboard bench for seg7_scan_capture: expected frames are queued by the stimulus, a monitor pops on Trama_lista.
module tb_seg7_scan_capture;

  logic        clk_disp, rst;
  logic [6:0]  Catodo;
  logic [3:0]  Seleccion;
  logic [6:0]  Unidades_rx, Decenas_rx, Actividad_rx, Estado_rx;
  logic [15:0] Digito_hex;
  logic [3:0]  Hex_valido;
  logic        Trama_lista, Error_sel, Sin_senal;

  seg7_scan_capture #(.STABLE_CYC(2), .TIMEOUT_CYC(16)) dut (
    .clk_disp(clk_disp), .rst(rst), .Catodo(Catodo), .Seleccion(Seleccion),
    .Unidades_rx(Unidades_rx), .Decenas_rx(Decenas_rx), .Actividad_rx(Actividad_rx),
    .Estado_rx(Estado_rx), .Digito_hex(Digito_hex), .Hex_valido(Hex_valido),
    .Trama_lista(Trama_lista), .Error_sel(Error_sel), .Sin_senal(Sin_senal)
  );

  typedef struct {
    logic [6:0]  u, d, a, e;
    logic [15:0] hex;
    logic [3:0]  vld;
  } frame_t;

  frame_t sb[$];
  int errors = 0;
  int checks = 0;
  int frames = 0;
  int cyc = 0;
  int last_trama_cyc = 0;

  initial begin
    clk_disp = 1'b0;
    forever #5 clk_disp = ~clk_disp;
  end

  initial forever begin
    @(posedge clk_disp);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [6:0] u, d, a, e, input logic [15:0] hex, input logic [3:0] vld);
    frame_t f;
    f.u = u; f.d = d; f.a = a; f.e = e;
`ifdef SEG7_RX_HEXDEC_EN
    f.hex = hex; f.vld = vld;
`else
    f.hex = 16'h0; f.vld = 4'h0;
`endif
    sb.push_back(f);
  endtask

  task automatic drive(input logic [3:0] sel, input logic [6:0] cat, input int n);
    Seleccion = sel;
    Catodo    = cat;
    repeat (n) @(negedge clk_disp);
  endtask

  task automatic scan_frame(input logic [6:0] u, d, a, e);
    drive(4'b0001, u, 8);
    drive(4'b0010, d, 8);
    drive(4'b0100, a, 8);
    drive(4'b1000, e, 8);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_u"}, 32'(Unidades_rx), 32'h7F);
    check({tag, "_d"}, 32'(Decenas_rx), 32'h7F);
    check({tag, "_a"}, 32'(Actividad_rx), 32'h7F);
    check({tag, "_e"}, 32'(Estado_rx), 32'h7F);
    check({tag, "_trama"}, 32'(Trama_lista), 32'h0);
    check({tag, "_err"}, 32'(Error_sel), 32'h0);
    check({tag, "_sin"}, 32'(Sin_senal), 32'h0);
    check({tag, "_hex"}, 32'(Digito_hex), 32'h0);
    check({tag, "_hexvld"}, 32'(Hex_valido), 32'h0);
  endtask

  // Monitor: every Trama_lista pulse must match the oldest queued frame
  initial forever begin
    @(negedge clk_disp);
    if (Trama_lista === 1'b1) begin
      frame_t f;
      frames++;
      last_trama_cyc = cyc;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got Trama_lista=1 expected no frame (u=%0h)", Unidades_rx);
      end else begin
        f = sb.pop_front();
        check("frame_u", 32'(Unidades_rx), 32'(f.u));
        check("frame_d", 32'(Decenas_rx), 32'(f.d));
        check("frame_a", 32'(Actividad_rx), 32'(f.a));
        check("frame_e", 32'(Estado_rx), 32'(f.e));
        check("frame_hex", 32'(Digito_hex), 32'(f.hex));
        check("frame_hexvld", 32'(Hex_valido), 32'(f.vld));
      end
    end
  end

  initial begin
    int target;
    rst = 1'b1;
    Seleccion = 4'h0;
    Catodo = 7'h7F;
    repeat (3) @(negedge clk_disp);
    check_reset_state("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk_disp);

    // Clean frame: 0,1,A,2
    push_exp(7'h40, 7'h79, 7'h08, 7'h24, 16'h2A10, 4'hF);
    scan_frame(7'h40, 7'h79, 7'h08, 7'h24);
    check("t1_frames", 32'(frames), 32'd1);
    check("t1_pulse_width", 32'(Trama_lista), 32'h0);

    // Multi-hot select between U and D must not capture and must latch Error_sel
    push_exp(7'h30, 7'h02, 7'h03, 7'h21, 16'hDB63, 4'hF);
    drive(4'b0001, 7'h30, 8);
    drive(4'b0011, 7'h00, 4);
    check("t2_err_set", 32'(Error_sel), 32'h1);
    check("t2_rx_u_kept", 32'(Unidades_rx), 32'h40);
    drive(4'b0010, 7'h02, 8);
    drive(4'b0100, 7'h03, 8);
    drive(4'b1000, 7'h21, 8);
    check("t2_frames", 32'(frames), 32'd2);
    check("t2_err_sticky", 32'(Error_sel), 32'h1);

    // Out-of-order U,A,D,E: no frame; clean frame afterwards completes
    drive(4'b0001, 7'h19, 8);
    drive(4'b0100, 7'h46, 8);
    drive(4'b0010, 7'h12, 8);
    drive(4'b1000, 7'h0E, 8);
    check("t3_no_frame", 32'(frames), 32'd2);
    check("t3_rx_e_kept", 32'(Estado_rx), 32'h21);
    push_exp(7'h19, 7'h12, 7'h46, 7'h0E, 16'hFC54, 4'hF);
    scan_frame(7'h19, 7'h12, 7'h46, 7'h0E);
    check("t3_frames", 32'(frames), 32'd3);

    // 1-cycle glitch on D is ignored; the 3-cycle D dwell is captured exactly once
    push_exp(7'h79, 7'h10, 7'h08, 7'h06, 16'hEA91, 4'hF);
    drive(4'b0001, 7'h79, 8);
    drive(4'b0010, 7'h78, 1);
    drive(4'b0010, 7'h10, 3);
    drive(4'b0100, 7'h08, 8);
    drive(4'b1000, 7'h06, 8);
    check("t4_frames", 32'(frames), 32'd4);

    // Scan stops: Sin_senal rises 16 cycles after the last frame
    drive(4'b0000, 7'h7F, 1);
    target = last_trama_cyc + 15;
    for (int i = 0; i < 40 && cyc < target; i++) @(negedge clk_disp);
    check("t5_cyc_reached", 32'(cyc), 32'(target));
    check("t5_sin_before", 32'(Sin_senal), 32'h0);
    @(negedge clk_disp);
    check("t5_sin_set", 32'(Sin_senal), 32'h1);
    repeat (5) @(negedge clk_disp);
    check("t5_sin_held", 32'(Sin_senal), 32'h1);
    push_exp(7'h40, 7'h79, 7'h08, 7'h24, 16'h2A10, 4'hF);
    scan_frame(7'h40, 7'h79, 7'h08, 7'h24);
    check("t5_sin_cleared", 32'(Sin_senal), 32'h0);
    check("t5_frames", 32'(frames), 32'd5);

    // Reset while waiting for A, then a full frame with an illegal (blank) Estado glyph
    drive(4'b0001, 7'h24, 8);
    drive(4'b0010, 7'h30, 8);
    drive(4'b0100, 7'h19, 1);
    rst = 1'b1;
    @(negedge clk_disp);
    check_reset_state("t6_rst");
    rst = 1'b0;
    drive(4'b0000, 7'h7F, 3);
    push_exp(7'h24, 7'h30, 7'h19, 7'h7F, 16'h0432, 4'h7);
    scan_frame(7'h24, 7'h30, 7'h19, 7'h7F);
    check("t6_frames", 32'(frames), 32'd6);
    check("t6_err_clear", 32'(Error_sel), 32'h0);

    drive(4'b0000, 7'h7F, 4);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("frames_total", 32'(frames), 32'd6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
